booth_mult_64: RTL and testbench
================================

BOOTH_MULT_64 -- requirements
Module: booth_mult_64

Interface
REQ-001 Parameter: OP_WIDTH, 32, operand width in bits; product width is 2*OP_WIDTH; only the default is supported.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  request to begin a multiply; sampled on the rising clk edge.
REQ-005 Port: multiplicand  in  32  signed two's-complement operand M; sampled only when start is accepted.
REQ-006 Port: multiplier  in  32  signed two's-complement operand Q; sampled only when start is accepted.
REQ-007 Port: product  out  64  signed product; registered; holds its value until the next result or reset.
REQ-008 Port: product_valid  out  1  one-cycle pulse marking a new product; drives write_enable of the downstream 64-bit result register.
REQ-009 Port: busy  out  1  high while a multiply is in progress; start is ignored while busy is high.
REQ-010 Port: overflow  out  1  present only when MULT_OVERFLOW_EN is defined (see Configuration).

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 Transitions: IDLE->RUN on start; RUN->DONE after the 32nd iteration; DONE->RUN on start, otherwise DONE->IDLE.
REQ-013 A start in IDLE or DONE SHALL load the registers as follows: M from multiplicand, A=0 (33 bits), Q from multiplier, Q-1=0, 6-bit iteration count=0.
REQ-014 In RUN, each cycle SHALL examine {Q[0],Q-1}: 01 gives A=A+M, 10 gives A=A-M, 00 and 11 leave A unchanged.
REQ-015 In the same cycle, {A,Q,Q-1} SHALL then shift right arithmetically by one bit and the count SHALL increment.
REQ-016 The accumulator A and sign-extended M SHALL be 33 bits so that M=-2^31 subtracts without wrap.
REQ-017 On the 32nd iteration, product SHALL load {A[31:0],Q} and product_valid SHALL be high for exactly one cycle (the DONE cycle).
REQ-018 Latency: start sampled at edge k gives busy high after edges k+1..k+32, and product/product_valid update at edge k+32.
REQ-019 busy SHALL be high only in RUN; it is low in IDLE and DONE.
REQ-020 A start asserted while busy=1 SHALL be ignored with no effect on any state or operand.
REQ-021 A start in the DONE cycle SHALL be accepted, giving back-to-back operation with a 33-cycle issue interval.
REQ-022 product SHALL NOT change in IDLE or RUN; only the DONE transition and reset change it.
REQ-023 Operand inputs SHALL be don't-care except at the accepting edge.

Reset
REQ-024 While reset=1, the block SHALL asynchronously force: state=IDLE, product=0, product_valid=0, busy=0, count=0, A/Q/Q-1/M=0, and overflow=0 if present.
REQ-025 Reset during RUN SHALL abort the operation with no product_valid pulse.
REQ-026 The first start after reset deasserts SHALL operate normally.

Configuration
REQ-027 Macro MULT_OVERFLOW_EN, when defined, SHALL add port overflow, registered alongside product.
REQ-028 overflow SHALL be 1 when product[63:31] is not all-equal, meaning the result does not fit in signed 32 bits; otherwise it is 0.
REQ-029 Without MULT_OVERFLOW_EN, the overflow port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Basic: start with M=3, Q=4 -> after 32 cycles, product=0x000000000000000C, product_valid pulses one cycle, and overflow=0.
REQ-031 Signed: M=-7, Q=6 -> product=0xFFFFFFFFFFFFFFD6; and M=-1, Q=-1 -> product=0x0000000000000001.
REQ-032 Extreme: M=Q=0x80000000 -> product=0x4000000000000000 and overflow=1 (with MULT_OVERFLOW_EN).
REQ-033 Busy ignore: start with new operands 5 cycles into RUN -> first result is unaffected, and no second product_valid pulse occurs.
REQ-034 Reset mid-operation: reset asserted at cycle 10 of RUN -> product=0, busy=0, no pulse; then M=2, Q=9 -> product=18.
REQ-035 Back-to-back: start held high continuously -> product_valid pulses every 33 cycles, and each product matches its operands.

Source files
------------

// File: rtl/booth_mult_64.sv
// Sequential radix-2 Booth multiplier: 32x32 signed -> 64-bit product, one iteration per clock.
// Optional macro MULT_OVERFLOW_EN adds a registered 'overflow' flag (product does not fit in 32 signed bits).
module booth_mult_64 #(
    parameter int OP_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [OP_WIDTH-1:0]     multiplicand,
    input  logic [OP_WIDTH-1:0]     multiplier,
    output logic [2*OP_WIDTH-1:0]   product,
    output logic                    product_valid,
    output logic                    busy
`ifdef MULT_OVERFLOW_EN
    ,
    output logic                    overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [OP_WIDTH:0]       r_a;
    logic [OP_WIDTH:0]       r_m;
    logic [OP_WIDTH-1:0]     r_q;
    logic                    r_q_m1;
    logic [5:0]              r_count;

    logic [OP_WIDTH:0]       w_a_sum;
    logic [OP_WIDTH:0]       w_a_next;
    logic [OP_WIDTH-1:0]     w_q_next;
    logic [2*OP_WIDTH-1:0]   w_product_next;
    logic                    w_last;
    logic                    w_accept;
`ifdef MULT_OVERFLOW_EN
    logic                    w_overflow_next;
`endif

    // NOTE: every signal in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_q_m1})
            2'b01:   w_a_sum = r_a + r_m;
            2'b10:   w_a_sum = r_a - r_m;
            default: w_a_sum = r_a;
        endcase
    end

    // Arithmetic right shift of the concatenation {A, Q, Q-1}; Q-1 picks up the old Q[0].
    assign w_a_next       = {w_a_sum[OP_WIDTH], w_a_sum[OP_WIDTH:1]};
    assign w_q_next       = {w_a_sum[0], r_q[OP_WIDTH-1:1]};
    assign w_product_next = {w_a_next[OP_WIDTH-1:0], w_q_next};
    assign w_last         = (r_count == 6'(OP_WIDTH - 1));
    assign w_accept       = start && (r_state != RUN);

`ifdef MULT_OVERFLOW_EN
    // Fits in signed 32 bits only when the upper 33 product bits are all copies of the sign.
    assign w_overflow_next = ~((&w_product_next[2*OP_WIDTH-1:OP_WIDTH-1]) |
                               ~(|w_product_next[2*OP_WIDTH-1:OP_WIDTH-1]));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_m           <= '0;
            r_q           <= '0;
            r_q_m1        <= 1'b0;
            r_count       <= '0;
            product       <= '0;
            product_valid <= 1'b0;
            busy          <= 1'b0;
`ifdef MULT_OVERFLOW_EN
            overflow      <= 1'b0;
`endif
        end else begin
            product_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_m     <= {multiplicand[OP_WIDTH-1], multiplicand};
                        r_a     <= '0;
                        r_q     <= multiplier;
                        r_q_m1  <= 1'b0;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_q_m1  <= r_q[0];
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        product       <= w_product_next;
                        product_valid <= 1'b1;
                        busy          <= 1'b0;
                        r_state       <= DONE;
`ifdef MULT_OVERFLOW_EN
                        overflow      <= w_overflow_next;
`endif
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_64.sv
// Randomized self-checking bench for booth_mult_64; products are predicted with native signed multiplication.
module tb_booth_mult_64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        product_valid;
    logic        busy;
`ifdef MULT_OVERFLOW_EN
    logic        overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic [63:0] exp_q[$];

    booth_mult_64 dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .product       (product),
        .product_valid (product_valid),
        .busy          (busy)
`ifdef MULT_OVERFLOW_EN
        ,
        .overflow      (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return 64'(a * b);
    endfunction

    // Monitor: every valid pulse must match the oldest accepted request; otherwise product must hold.
    initial begin
        logic [63:0] held;
        logic [63:0] e;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = '0;
            end else if (product_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(product_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", product, e);
`ifdef MULT_OVERFLOW_EN
                    check("overflow", 64'(overflow), 64'(e[63:31] != '0 && e[63:31] != '1));
`endif
                end
                held = product;
            end else begin
                check("hold", product, held);
            end
        end
    end

    // One multiply from IDLE; optional stray start 'poke' cycles into RUN must be ignored.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int poke);
        @(posedge clk); #1;
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        exp_q.push_back(ref_mul(m, q));
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check("busy_accept", 64'(busy), 64'd1);
        for (int c = 1; c < 32; c++) begin
            start = (c == poke);
            if (c == poke) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            @(posedge clk); #1;
            check("busy_run", 64'(busy), 64'd1);
            check("valid_run", 64'(product_valid), 64'd0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("valid_done", 64'(product_valid), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("valid_pulse_end", 64'(product_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    // Start held high: a new request is accepted in each DONE cycle.
    task automatic run_b2b(input int n);
        logic [31:0] m;
        logic [31:0] q;
        int          last_pulse;
        last_pulse = -1;
        @(posedge clk); #1;
        m = $urandom; q = $urandom;
        start = 1'b1; multiplicand = m; multiplier = q;
        exp_q.push_back(ref_mul(m, q));
        for (int op = 0; op < n; op++) begin
            @(posedge clk); #1;
            check("b2b_busy_accept", 64'(busy), 64'd1);
            check("b2b_valid_low", 64'(product_valid), 64'd0);
            if (op < n - 1) begin
                m = $urandom; q = $urandom;
                multiplicand = m; multiplier = q;
                exp_q.push_back(ref_mul(m, q));
            end else begin
                start = 1'b0;
                multiplicand = $urandom; multiplier = $urandom;
            end
            repeat (32) @(posedge clk);
            #1;
            check("b2b_valid", 64'(product_valid), 64'd1);
            check("b2b_busy_done", 64'(busy), 64'd0);
            if (last_pulse >= 0) check("b2b_interval", 64'(cyc - last_pulse), 64'd33);
            last_pulse = cyc;
        end
        @(posedge clk); #1;
        check("b2b_valid_end", 64'(product_valid), 64'd0);
        check("b2b_busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corner [5];
        logic [31:0] m;
        logic [31:0] q;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", product, 64'd0);
        check("rst_valid", 64'(product_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
`ifdef MULT_OVERFLOW_EN
        check("rst_overflow", 64'(overflow), 64'd0);
`endif
        reset = 1'b0;

        run_op(32'd3, 32'd4, -1);
        check("basic_const", product, 64'h0000_0000_0000_000C);
        run_op(32'hFFFF_FFF9, 32'd6, -1);
        check("signed_const", product, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("neg_one_const", product, 64'h0000_0000_0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, -1);
        check("extreme_const", product, 64'h4000_0000_0000_0000);
`ifdef MULT_OVERFLOW_EN
        check("extreme_overflow", 64'(overflow), 64'd1);
`endif
        run_op(32'h1234_5678, 32'hFEDC_BA98, 5);

        for (int i = 0; i < 12; i++) begin
            m = $urandom;
            q = $urandom;
            if (i % 4 == 0) m = corner[$urandom_range(0, 4)];
            if (i % 3 == 0) q = corner[$urandom_range(0, 4)];
            run_op(m, q, (i % 2 == 0) ? int'($urandom_range(1, 31)) : -1);
        end

        // Abort mid-run: no pulse, outputs cleared, next operation normal.
        @(posedge clk); #1;
        start = 1'b1; multiplicand = $urandom; multiplier = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("abort_product", product, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(product_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(32'd2, 32'd9, -1);
        check("after_reset_const", product, 64'd18);

        run_b2b(4);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
